// File: rtl/fifo_stream_reader_pkg.sv
// Shared types and helpers for the fifo read-side stream master.
package fifo_rd_pkg;

  // Number of words the skid buffer can hold.
  localparam int SKID_DEPTH = 2;

  // Skid occupancy, 0..SKID_DEPTH.
  typedef logic [1:0] occ_t;

  // A new pop may be issued only if every word already held or still in
  // flight from the fifo, less the one leaving this cycle, leaves a free slot.
  // That guarantees a returning word always has somewhere to land.
  function automatic logic credit_ok(input occ_t occ, input logic inflight,
                                     input logic xfer);
    logic [2:0] committed;
    committed = 3'(occ) + 3'(inflight) - 3'(xfer);
    return committed < 3'(SKID_DEPTH);
  endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// Valid/ready stream carrying fifo words toward the downstream consumer.
interface fifo_stream_reader_if #(
  parameter int WIDTH = 8
);

  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  // Producer side: drives the word and its valid, samples ready.
  modport master (
    output valid,
    output data,
    input  ready
  );

  // Consumer side: samples the word, drives ready.
  modport slave (
    input  valid,
    input  data,
    output ready
  );

endinterface

// File: rtl/fifo_stream_reader_skid_buf.sv
// Two-entry shift buffer. entry0 is always the head of the stream; a pop
// shifts entry1 down, and a push lands in the first slot that is free after
// that shift. A flush empties the buffer and refuses the word pushed that
// cycle.
module fifo_skid_buf
  import fifo_rd_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic             head_valid_o,
  output logic [WIDTH-1:0] head_data_o,
  output occ_t             occ_o
);

  logic [WIDTH-1:0] entry0_q, entry0_d;
  logic [WIDTH-1:0] entry1_q, entry1_d;
  occ_t             occ_q, occ_d;
  occ_t             occ_after_pop;
  logic             push_ok;

  // A flush discards everything, including the word arriving this cycle.
  assign push_ok = push_i && !flush_i;

  // Next entry contents: shift on pop first, then place the incoming word.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // through the block leaves one unassigned and no latch is inferred.
    entry0_d      = entry0_q;
    entry1_d      = entry1_q;
    occ_after_pop = occ_q - occ_t'(pop_i);

    if (pop_i) begin
      entry0_d = entry1_q;
    end

    if (push_ok) begin
      if (occ_after_pop == '0) begin
        entry0_d = push_data_i;
      end else begin
        entry1_d = push_data_i;
      end
    end

    occ_d = occ_after_pop + occ_t'(push_ok);
    if (flush_i) begin
      occ_d = '0;
    end
  end

  // Entry and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the two entries are ordinary flops rather than a RAM array,
      // so they are reset; that gives the stream a defined data value of 0
      // coming out of reset.
      entry0_q <= '0;
      entry1_q <= '0;
      occ_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments, so every flop here samples the
      // values from before the edge regardless of statement order.
      entry0_q <= entry0_d;
      entry1_q <= entry1_d;
      occ_q    <= occ_d;
    end
  end

  assign head_valid_o = (occ_q != '0);
  assign head_data_o  = entry0_q;
  assign occ_o        = occ_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side master for a synchronous fifo. It issues pops only when the skid
// buffer is guaranteed room for the returning word. The word is captured one
// cycle after the pop and presented as a valid/ready stream that sustains one
// word per clock. Transfers and flushed words are counted.
module fifo_stream_reader
  import fifo_rd_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  // fifo read port
  output logic                 fifo_rd_en,
  input  logic [WIDTH-1:0]     fifo_dout,
  input  logic                 fifo_empty,
  // control
  input  logic                 flush,
  // downstream stream
  fifo_stream_reader_if.master m_if,
  // statistics and status
  output logic [CNT_W-1:0]     pop_count,
  output logic [CNT_W-1:0]     drop_count,
  output logic                 busy
);

  logic             inflight_q, inflight_d;
  logic [CNT_W-1:0] pop_count_q, pop_count_d;
  logic [CNT_W-1:0] drop_count_q, drop_count_d;

  occ_t             occ;
  logic             head_valid;
  logic [WIDTH-1:0] head_data;
  logic             xfer;

  // A word leaves the buffer whenever the consumer accepts the head.
  assign xfer = head_valid && m_if.ready;

  // Pop only when the fifo has data, no flush is discarding the pipeline,
  // and the buffer will have room for the word when it returns.
  assign fifo_rd_en = !fifo_empty && !flush && credit_ok(occ, inflight_q, xfer);

  // fifo_dout is only meaningful the cycle after a pop, which is exactly
  // when inflight_q is set, so inflight_q doubles as the push strobe.
  fifo_skid_buf #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (inflight_q),
    .push_data_i  (fifo_dout),
    .pop_i        (xfer),
    .flush_i      (flush),
    .head_valid_o (head_valid),
    .head_data_o  (head_data),
    .occ_o        (occ)
  );

  // In-flight tracking and statistics next-state. A transfer in the flush
  // cycle is delivered, so it is counted as a pop and excluded from the drop.
  always_comb begin
    inflight_d   = fifo_rd_en;
    pop_count_d  = pop_count_q + CNT_W'(xfer);
    drop_count_d = drop_count_q;
    if (flush) begin
      drop_count_d = drop_count_q + CNT_W'(occ) - CNT_W'(xfer) + CNT_W'(inflight_q);
    end
  end

  // In-flight flag and counter registers; counters wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q   <= 1'b0;
      pop_count_q  <= '0;
      drop_count_q <= '0;
    end else begin
      inflight_q   <= inflight_d;
      pop_count_q  <= pop_count_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign m_if.valid = head_valid;
  assign m_if.data  = head_data;
  assign pop_count  = pop_count_q;
  assign drop_count = drop_count_q;
  assign busy       = head_valid || inflight_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: a behavioural 8x16 fifo feeds the reader,
// and a word-order scoreboard plus scenario checks judge the stream.
module tb_fifo_stream_reader;

  localparam int WIDTH = 8;
  localparam int CNT_W = 16;
  localparam int DEPTH = 16;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             wr_en = 1'b0;
  logic [WIDTH-1:0] din   = '0;
  logic             flush = 1'b0;
  logic             fifo_rd_en;
  logic [WIDTH-1:0] fifo_dout;
  logic             fifo_empty;
  logic             fifo_full;
  logic [CNT_W-1:0] pop_count;
  logic [CNT_W-1:0] drop_count;
  logic             busy;

  fifo_stream_reader_if #(.WIDTH(WIDTH)) m_if ();

  fifo_stream_reader #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_rd_en (fifo_rd_en),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .flush      (flush),
    .m_if       (m_if),
    .pop_count  (pop_count),
    .drop_count (drop_count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Behavioural synchronous fifo, sharing rst_n with the reader.
  logic [WIDTH-1:0] fmem [DEPTH];
  logic [3:0]       fwp, frp;
  logic [4:0]       fifo_cnt;

  assign fifo_empty = (fifo_cnt == 5'd0);
  assign fifo_full  = (fifo_cnt == 5'(DEPTH));

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwp       <= '0;
      frp       <= '0;
      fifo_cnt  <= '0;
      fifo_dout <= '0;
    end else begin
      if (wr_en && !fifo_full) begin
        fmem[fwp] <= din;
        fwp       <= fwp + 4'd1;
      end
      if (fifo_rd_en && !fifo_empty) begin
        fifo_dout <= fmem[frp];
        frp       <= frp + 4'd1;
      end
      fifo_cnt <= fifo_cnt + 5'(wr_en && !fifo_full) - 5'(fifo_rd_en && !fifo_empty);
    end
  end

  // Reference model: words accepted by the fifo and not yet delivered/dropped.
  logic [WIDTH-1:0] exp_q[$];
  int               exp_pop   = 0;
  int               exp_drop  = 0;
  int               n_written = 0;
  int               n_checks  = 0;
  int               n_fail    = 0;

  logic             obs_valid, obs_xfer, obs_rd_en, obs_empty, obs_busy;
  logic [WIDTH-1:0] obs_data;
  logic             prev_hold = 1'b0;
  logic [WIDTH-1:0] prev_data = '0;

  // One clock: drive inputs just after a falling edge, sample mid-cycle,
  // update the model, then wait for the next falling edge.
  task automatic step(input logic w, input logic [WIDTH-1:0] d,
                      input logic r, input logic f);
    logic [WIDTH-1:0] e;
    int               n_drop;
    wr_en       = w;
    din         = d;
    m_if.ready  = r;
    flush       = f;
    #1;
    obs_valid = m_if.valid;
    obs_data  = m_if.data;
    obs_rd_en = fifo_rd_en;
    obs_empty = fifo_empty;
    obs_busy  = busy;
    obs_xfer  = m_if.valid && r;

    n_checks++;
    if (fifo_empty === 1'b1 && fifo_rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_en_while_empty: rd_en=%b, required 0", fifo_rd_en);
    end
    if (f) begin
      n_checks++;
      if (fifo_rd_en !== 1'b0) begin
        n_fail++;
        $display("FAIL rd_en_during_flush: rd_en=%b, required 0", fifo_rd_en);
      end
    end
    if (prev_hold) begin
      n_checks++;
      if (obs_valid !== 1'b1 || obs_data !== prev_data) begin
        n_fail++;
        $display("FAIL hold_stable: valid=%b data=%h, required valid=1 data=%h",
                 obs_valid, obs_data, prev_data);
      end
    end
    if (obs_xfer) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL spurious_word: data=%h delivered, required none", obs_data);
      end else begin
        e = exp_q.pop_front();
        if (obs_data !== e) begin
          n_fail++;
          $display("FAIL stream_data: data=%h, required %h", obs_data, e);
        end
      end
      exp_pop++;
    end
    if (f) begin
      // Everything accepted by the fifo but no longer inside it is held by
      // the reader (buffered or in flight) and is discarded.
      n_drop = exp_q.size() - int'(fifo_cnt);
      for (int k = 0; k < n_drop; k++) void'(exp_q.pop_front());
      exp_drop += n_drop;
    end
    if (w && !fifo_full) begin
      exp_q.push_back(d);
      n_written++;
    end
    prev_hold = obs_valid && !r && !f;
    prev_data = obs_data;
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    n_checks++;
    if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL %s_rd_en: got %b, required 0", tag, fifo_rd_en); end
    n_checks++;
    if (m_if.valid !== 1'b0) begin n_fail++; $display("FAIL %s_valid: got %b, required 0", tag, m_if.valid); end
    n_checks++;
    if (m_if.data !== '0) begin n_fail++; $display("FAIL %s_data: got %h, required 0", tag, m_if.data); end
    n_checks++;
    if (pop_count !== '0) begin n_fail++; $display("FAIL %s_pop_count: got %0d, required 0", tag, pop_count); end
    n_checks++;
    if (drop_count !== '0) begin n_fail++; $display("FAIL %s_drop_count: got %0d, required 0", tag, drop_count); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL %s_busy: got %b, required 0", tag, busy); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n     = 1'b1;
    prev_hold = 1'b0;
  endtask

  task automatic test_streaming();
    int t_empty = -1, t_valid = -1, n_x = 0, gaps = 0;
    for (int i = 0; i < 30; i++) begin
      if (i < 10) step(1'b1, WIDTH'(i + 1), 1'b1, 1'b0);
      else        step(1'b0, '0, 1'b1, 1'b0);
      if (t_empty < 0 && !obs_empty) t_empty = i;
      if (t_valid < 0 && obs_valid)  t_valid = i;
      if (obs_xfer) n_x++;
      else if (n_x > 0 && n_x < 10) gaps++;
    end
    n_checks++;
    if (t_empty < 0 || t_valid - t_empty != 2) begin
      n_fail++;
      $display("FAIL stream_latency: valid %0d cycles after empty fell, required 2", t_valid - t_empty);
    end
    n_checks++;
    if (n_x != 10 || gaps != 0) begin
      n_fail++;
      $display("FAIL stream_back_to_back: %0d words with %0d gaps, required 10 with 0", n_x, gaps);
    end
    n_checks++;
    if (pop_count !== 16'd10) begin
      n_fail++;
      $display("FAIL stream_pop_count: got %0d, required 10", pop_count);
    end
  endtask

  task automatic test_backpressure();
    int n_x = 0, gaps = 0;
    for (int k = 0; k < 5; k++) step(1'b1, WIDTH'(k + 1), 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) step(1'b0, '0, 1'b0, 1'b0);
    n_checks++;
    if (fifo_cnt !== 5'd3) begin
      n_fail++;
      $display("FAIL bp_fifo_level: fifo holds %0d, required 3", fifo_cnt);
    end
    n_checks++;
    if (obs_valid !== 1'b1 || obs_data !== 8'h01 || obs_rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_head: valid=%b data=%h rd_en=%b, required 1/01/0", obs_valid, obs_data, obs_rd_en);
    end
    for (int k = 0; k < 12; k++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      if (obs_xfer) n_x++;
      else if (n_x > 0 && n_x < 5) gaps++;
    end
    n_checks++;
    if (n_x != 5 || gaps != 0) begin
      n_fail++;
      $display("FAIL bp_release: %0d words with %0d gaps, required 5 with 0", n_x, gaps);
    end
    n_checks++;
    if (pop_count !== 16'd15) begin
      n_fail++;
      $display("FAIL bp_pop_count: got %0d, required 15", pop_count);
    end
  endtask

  task automatic test_underflow();
    logic vv [16];
    int   last = -1, n_x = 0;
    for (int i = 0; i < 16; i++) begin
      step(i < 3, WIDTH'(8'h30 + i), 1'b1, 1'b0);
      vv[i] = obs_valid;
      if (obs_xfer) begin last = i; n_x++; end
    end
    n_checks++;
    if (n_x != 3 || last < 0 || last > 14 || vv[last + 1] !== 1'b0) begin
      n_fail++;
      $display("FAIL uf_valid_drop: %0d words, valid after last=%b, required 3 words then 0",
               n_x, (last >= 0 && last < 15) ? vv[last + 1] : 1'bx);
    end
    n_checks++;
    if (obs_valid !== 1'b0 || obs_busy !== 1'b0 || fifo_cnt !== 5'd0) begin
      n_fail++;
      $display("FAIL uf_idle: valid=%b busy=%b fifo=%0d, required 0/0/0", obs_valid, obs_busy, fifo_cnt);
    end
  endtask

  task automatic test_flush();
    // Buffer full, nothing in flight, consumer stalled.
    for (int k = 0; k < 4; k++) step(1'b1, WIDTH'(8'h10 + k), 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0);
    n_checks++;
    if (obs_valid !== 1'b0 || obs_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_clear: valid=%b busy=%b after flush, required 0/0", obs_valid, obs_busy);
    end
    n_checks++;
    if (drop_count !== 16'd2) begin
      n_fail++;
      $display("FAIL flush_drop: got %0d, required 2", drop_count);
    end
    for (int k = 0; k < 10; k++) step(1'b0, '0, 1'b1, 1'b0);

    // Flush with a transfer in the same cycle: the head is delivered.
    for (int k = 0; k < 3; k++) step(1'b1, WIDTH'(8'h20 + k), 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0);
    n_checks++;
    if (obs_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_xfer_clear: valid=%b, required 0", obs_valid);
    end
    for (int k = 0; k < 10; k++) step(1'b0, '0, 1'b1, 1'b0);
    n_checks++;
    if (drop_count !== 16'd3 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL flush_xfer_drop: drop=%0d pending=%0d, required 3/0", drop_count, exp_q.size());
    end
    n_checks++;
    if (pop_count !== 16'(exp_pop)) begin
      n_fail++;
      $display("FAIL flush_pop_count: got %0d, required %0d", pop_count, exp_pop);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++) begin
      step($urandom_range(0, 2) != 0, WIDTH'($urandom), $urandom_range(0, 3) != 0,
           $urandom_range(0, 19) == 0);
    end
    for (int i = 0; i < 40; i++) step(1'b0, '0, 1'b1, 1'b0);
    n_checks++;
    if (exp_q.size() != 0 || obs_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rand_drain: %0d words undelivered, busy=%b, required 0/0", exp_q.size(), obs_busy);
    end
    n_checks++;
    if (pop_count !== 16'(n_written - exp_drop)) begin
      n_fail++;
      $display("FAIL rand_pop_count: got %0d, required %0d", pop_count, n_written - exp_drop);
    end
    n_checks++;
    if (drop_count !== 16'(exp_drop)) begin
      n_fail++;
      $display("FAIL rand_drop_count: got %0d, required %0d", drop_count, exp_drop);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 6; i++) step(1'b1, WIDTH'(8'h40 + i), i > 2, 1'b0);
    wr_en = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("mid_reset");
    #19;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    exp_pop   = 0;
    exp_drop  = 0;
    n_written = 0;
    prev_hold = 1'b0;
    for (int i = 0; i < 10; i++) step(i < 3, WIDTH'(8'h50 + i), 1'b1, 1'b0);
    n_checks++;
    if (pop_count !== 16'd3 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL post_reset_stream: pop=%0d pending=%0d, required 3/0", pop_count, exp_q.size());
    end
  endtask

  initial begin
    m_if.ready = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_underflow();
    test_flush();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
